cb_config_sequencer: RTL and testbench

- Master sequencer for the connection-box configuration shift chains.
- Accepts a byte-wide bitstream over a valid/ready handshake and serialises it MSB-first onto the chain data line.
- Drives global prgm_b and one per-segment program enable (cb_prgm_b) so that exactly one CB segment shifts at a time, each for SEG_BITS cycles.
- Segments load in index order; the block signals done when the last segment is full.

---
 rtl/cb_config_sequencer_if.sv | 19 +
 rtl/cb_config_sequencer.sv | 163 ++++++++++++++++
 tb/tb_cb_config_sequencer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cb_config_sequencer_if.sv
// Byte-wide bitstream handshake into the connection-box config sequencer.
// A byte moves on any rising edge where byte_valid and byte_ready are both high.
interface cb_config_sequencer_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready
    );
endinterface

// File: rtl/cb_config_sequencer.sv
// Serialises a byte stream MSB-first into NUM_SEG CB config chains, one segment at a time.
// First bit appears the cycle after its byte is accepted; byte_ready drops while the buffer still holds >1 bit.
module cb_config_sequencer #(
    parameter  int NUM_SEG    = 4,
    parameter  int SEG_BITS   = 48,
    parameter  int PRGM_SETUP = 2,
    localparam int SEG_W      = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    cb_config_sequencer_if.slave   bs,
    output logic                   bit_out,
    output logic                   shift_en,
    output logic                   prgm_b,
    output logic [NUM_SEG-1:0]     cb_prgm_b,
    output logic [SEG_W-1:0]       seg_idx,
    output logic                   busy,
    output logic                   done
);

    localparam int CNT_W = $clog2(SEG_BITS);
    localparam int SU_W  = (PRGM_SETUP > 1) ? $clog2(PRGM_SETUP) : 1;

    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(SEG_BITS - 1);
    localparam logic [SU_W-1:0]  LAST_SETUP = SU_W'(PRGM_SETUP - 1);
    localparam logic [SEG_W-1:0] LAST_SEG   = SEG_W'(NUM_SEG - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [SU_W-1:0]  setup_cnt_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [SEG_W-1:0] seg_idx_q;
    logic [7:0]       buf_q;
    logic [3:0]       buf_cnt_q;

    logic buf_busy;
    logic shift;
    logic seg_end;
    logic last_seg;
    logic rdy;
    logic take;

    assign buf_busy = (buf_cnt_q != 4'd0);
    assign shift    = (state_q == S_SHIFT) && buf_busy;
    assign seg_end  = shift && (bit_cnt_q == LAST_BIT);
    assign last_seg = (seg_idx_q == LAST_SEG);

    // Refill on the final bit of a byte keeps one bit per clock; the last bit of the
    // pass must not pull in a byte that belongs to the next pass.
    assign rdy = (state_q == S_SHIFT) && !abort &&
                 (!buf_busy || ((buf_cnt_q == 4'd1) && !(seg_end && last_seg)));
    assign take = rdy && bs.byte_valid;

    assign bs.byte_ready = rdy;
    assign shift_en      = shift;
    assign bit_out       = shift ? buf_q[7] : 1'b0;
    assign seg_idx       = seg_idx_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        prgm_b    = 1'b1;
        cb_prgm_b = '0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                prgm_b = 1'b0;
                if (setup_cnt_q == LAST_SETUP) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                prgm_b    = 1'b0;
                cb_prgm_b = NUM_SEG'(1) << seg_idx_q;
                if (seg_end) begin
                    state_d = last_seg ? S_DONE : S_GAP;
                end
            end
            S_GAP: begin
                prgm_b  = 1'b0;
                state_d = S_SHIFT;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            setup_cnt_q <= '0;
            bit_cnt_q   <= '0;
            seg_idx_q   <= '0;
            buf_q       <= '0;
            buf_cnt_q   <= '0;
        end else if (abort) begin
            setup_cnt_q <= '0;
            bit_cnt_q   <= '0;
            seg_idx_q   <= '0;
            buf_q       <= '0;
            buf_cnt_q   <= '0;
        end else begin
            if (state_q == S_SETUP) begin
                setup_cnt_q <= setup_cnt_q + SU_W'(1);
            end else begin
                setup_cnt_q <= '0;
            end

            if (take) begin
                buf_q     <= bs.byte_in;
                buf_cnt_q <= 4'd8;
            end else if (shift) begin
                buf_q     <= {buf_q[6:0], 1'b0};
                buf_cnt_q <= buf_cnt_q - 4'd1;
            end

            // Stalls leave the count untouched so a throttled source still lands SEG_BITS per segment.
            if (seg_end) begin
                bit_cnt_q <= '0;
            end else if (shift) begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end

            if (state_q == S_GAP) begin
                seg_idx_q <= seg_idx_q + SEG_W'(1);
            end else if (state_q == S_DONE) begin
                seg_idx_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cb_config_sequencer.sv
// Directed bench: default 4x48 instance for full passes, reset/abort/start-ignore cases,
// and a 2-segment instance fed by a sparse source.
module tb_cb_config_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, abort, start2, abort2;

    cb_config_sequencer_if bs();
    cb_config_sequencer_if bs2();

    logic       bit_out, shift_en, prgm_b, busy, done;
    logic [3:0] cb_prgm_b;
    logic [1:0] seg_idx;
    logic       bit_out2, shift_en2, prgm_b2, busy2, done2;
    logic [1:0] cb_prgm_b2;
    logic [0:0] seg_idx2;

    cb_config_sequencer u_dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .bs(bs),
        .bit_out(bit_out), .shift_en(shift_en), .prgm_b(prgm_b), .cb_prgm_b(cb_prgm_b),
        .seg_idx(seg_idx), .busy(busy), .done(done)
    );

    cb_config_sequencer #(.NUM_SEG(2), .SEG_BITS(48), .PRGM_SETUP(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .abort(abort2), .bs(bs2),
        .bit_out(bit_out2), .shift_en(shift_en2), .prgm_b(prgm_b2), .cb_prgm_b(cb_prgm_b2),
        .seg_idx(seg_idx2), .busy(busy2), .done(done2)
    );

    int checks = 0;
    int errors = 0;

    int cyc, xfers, shifts, dones, done_cyc, gaps, bubbles, rdy_on_shift;
    int seg_sh[4];
    logic        done_prgm;
    logic        seen_seg;
    logic [47:0] seg0_bits;
    logic [3:0]  cb_q[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        cyc = 0; xfers = 0; shifts = 0; dones = 0; done_cyc = 0;
        gaps = 0; bubbles = 0; rdy_on_shift = 0;
        for (int i = 0; i < 4; i++) seg_sh[i] = 0;
        done_prgm = 1'b0;
        seen_seg  = 1'b0;
        seg0_bits = '0;
        cb_q = {};
        cb_q.push_back(cb_prgm_b);
        bs.byte_in = 8'h00;
    endtask

    // Sample mid-cycle, then advance the source past the edge if a byte moved.
    task automatic tick();
        logic xfer;
        @(negedge clk);
        cyc++;
        xfer = bs.byte_valid && bs.byte_ready;
        if (xfer) xfers++;
        if (shift_en) begin
            shifts++;
            seg_sh[seg_idx]++;
            if (cb_prgm_b == 4'b0001) seg0_bits = {seg0_bits[46:0], bit_out};
            if (bs.byte_ready) rdy_on_shift++;
        end
        if (cb_prgm_b != 4'b0000) seen_seg = 1'b1;
        if (cb_prgm_b != 4'b0000 && !shift_en) bubbles++;
        if (busy && seen_seg && cb_prgm_b == 4'b0000 && !done) gaps++;
        if (done) begin
            dones++;
            done_cyc  = cyc;
            done_prgm = prgm_b;
        end
        if (cb_q[$] != cb_prgm_b) cb_q.push_back(cb_prgm_b);
        @(posedge clk);
        #1;
        if (xfer) bs.byte_in = bs.byte_in + 8'd1;
    endtask

    // Cycle 1 is the first cycle after the edge that samples start; p1/p2 pulse start mid-pass.
    task automatic run_pass(input int p1, input int p2);
        clr_stats();
        bs.byte_valid = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (dones == 0 && cyc < 400) begin
            start = (cyc == p1 || cyc == p2);
            tick();
        end
        start = 1'b0;
        repeat (3) tick();
    endtask

    task automatic check_full(input string p);
        logic [35:0] seq;
        seq = '0;
        foreach (cb_q[i]) seq = {seq[31:0], cb_q[i]};
        chk({p, "_xfers"}, xfers, 24);
        chk({p, "_shifts"}, shifts, 192);
        chk({p, "_dones"}, dones, 1);
        chk({p, "_done_cyc"}, done_cyc, 199);
        chk({p, "_done_prgm_b"}, done_prgm, 1'b1);
        chk({p, "_seg_shifts"}, {seg_sh[0], seg_sh[1], seg_sh[2], seg_sh[3]}, {32'd48, 32'd48, 32'd48, 32'd48});
        chk({p, "_rdy_on_8th"}, rdy_on_shift, 23);
        chk({p, "_bubbles"}, bubbles, 1);
        chk({p, "_gap_cycles"}, gaps, 3);
        chk({p, "_seg0_bits"}, seg0_bits, 48'h000102030405);
        chk({p, "_cb_len"}, cb_q.size(), 9);
        chk({p, "_cb_seq"}, seq, 36'h010204080);
        chk({p, "_idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] bits2, exp96;
        int c, x2, sh2, d2, bursts2, bad2, run_len;
        int seg2_sh[2];
        logic xfer2;

        reset = 1'b0; start = 1'b0; abort = 1'b0; start2 = 1'b0; abort2 = 1'b0;
        bs.byte_in = 8'h00;  bs.byte_valid = 1'b0;
        bs2.byte_in = 8'h00; bs2.byte_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_prgm_b", prgm_b, 1'b1);
        chk("rst_cb_prgm_b", cb_prgm_b, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_shift_en", shift_en, 1'b0);
        chk("rst_bit_out", bit_out, 1'b0);
        chk("rst_seg_idx", seg_idx, 2'd0);
        chk("rst_byte_ready", bs.byte_ready, 1'b0);
        chk("rst2_prgm_b", prgm_b2, 1'b1);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Full pass with a continuously valid source.
        run_pass(-1, -1);
        check_full("pass1");

        // Reset 10 shifts into segment 1, then a clean restart.
        clr_stats();
        bs.byte_valid = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (seg_sh[1] < 10 && cyc < 400) tick();
        chk("rst_mid_seg1_shifts", seg_sh[1], 10);
        reset = 1'b0;
        #1;
        chk("rst_mid_prgm_b", prgm_b, 1'b1);
        chk("rst_mid_cb_prgm_b", cb_prgm_b, 4'b0000);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_shift_en", shift_en, 1'b0);
        chk("rst_mid_seg_idx", seg_idx, 2'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        run_pass(-1, -1);
        check_full("restart");

        // Abort 7 shifts into segment 2, when the buffer holds its last bit.
        clr_stats();
        bs.byte_valid = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (seg_sh[2] < 7 && cyc < 400) tick();
        chk("abort_seg_idx", seg_idx, 2'd2);
        abort = 1'b1;
        @(negedge clk);
        chk("abort_byte_ready", bs.byte_ready, 1'b0);
        chk("abort_done", done, 1'b0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_prgm_b_next", prgm_b, 1'b1);
        chk("abort_busy_next", busy, 1'b0);
        chk("abort_seg_idx_next", seg_idx, 2'd0);
        chk("abort_no_done", dones, 0);
        run_pass(-1, -1);
        check_full("after_abort");

        // start pulsed mid-pass and again during DONE must change nothing.
        run_pass(50, 198);
        check_full("start_ignored");

        // Two-segment instance, one byte offered every 12 cycles.
        exp96 = '0;
        for (int i = 0; i < 12; i++) exp96 = {exp96[87:0], 8'(i)};
        bits2 = '0;
        x2 = 0; sh2 = 0; d2 = 0; bursts2 = 0; bad2 = 0; run_len = 0; c = 0;
        seg2_sh[0] = 0; seg2_sh[1] = 0;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        while (d2 == 0 && c < 1000) begin
            bs2.byte_valid = (c % 12 == 0);
            @(negedge clk);
            c++;
            xfer2 = bs2.byte_valid && bs2.byte_ready;
            if (xfer2) x2++;
            if (shift_en2) begin
                sh2++;
                seg2_sh[seg_idx2]++;
                bits2 = {bits2[94:0], bit_out2};
                run_len++;
            end else if (run_len != 0) begin
                bursts2++;
                if (run_len != 8) bad2++;
                run_len = 0;
            end
            if (done2) d2++;
            @(posedge clk);
            #1;
            if (xfer2) bs2.byte_in = bs2.byte_in + 8'd1;
        end
        bs2.byte_valid = 1'b0;
        chk("thr_xfers", x2, 12);
        chk("thr_shifts", sh2, 96);
        chk("thr_dones", d2, 1);
        chk("thr_bursts", bursts2, 12);
        chk("thr_bad_bursts", bad2, 0);
        chk("thr_seg_shifts", {seg2_sh[0], seg2_sh[1]}, {32'd48, 32'd48});
        chk("thr_bits", bits2, exp96);
        @(posedge clk);
        #1;
        chk("thr_idle_prgm_b", prgm_b2, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
